// File: rtl/sorter_batch_ctrl.sv
// -----------------------------------------------------------------------------
// sorter_batch_ctrl
//
// Sequencer in front of the multi-width top-k sorter. One batch at a time:
//   1. accept a configuration (signedness, channel size, k),
//   2. collect the batch elements into a local buffer, padding unused slots,
//   3. issue a single launch pulse to the sorter,
//   4. wait (bounded) for the sorter's done flag and capture its result,
//   5. stream the k largest results out through a ready/valid port.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   cfg_valid_i/cfg_ready_o configuration handshake
//   cfg_sign_i              1 = signed compare
//   cfg_channel_i           1:4, 2:8, 3:16, 4:32 elements (others illegal)
//   cfg_k_i                 number of results to emit (0 or >N means N)
//   in_valid_i/in_ready_o   element stream handshake
//   in_data_i, in_last_i    element and end-of-batch marker
//   srt_start_o             one-cycle sorter launch
//   srt_sign_o              sign control to the sorter, held while busy
//   srt_channel_o           channel code to the sorter, 0 when idle
//   srt_data_o              buffered elements, element i at [i*DATAWIDTH +: DATAWIDTH]
//   srt_done_i              sorter result valid (level or pulse)
//   srt_result_i            sorted result, index 0 = largest
//   out_valid_o/out_ready_i result stream handshake
//   out_data_o, out_last_o  result element and k-th result marker
//   busy_o                  a batch is in flight
//   err_o                   one-cycle pulse: illegal channel or sorter timeout
// -----------------------------------------------------------------------------
module sorter_batch_ctrl #(
    parameter int DATAWIDTH      = 8,
    parameter int MAX_DATALENGTH = 32,
    parameter int TIMEOUT        = 64,
    parameter int KW             = 6
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                cfg_valid_i,
    output logic                                cfg_ready_o,
    input  logic                                cfg_sign_i,
    input  logic [2:0]                          cfg_channel_i,
    input  logic [KW-1:0]                       cfg_k_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [DATAWIDTH-1:0]                in_data_i,
    input  logic                                in_last_i,
    output logic                                srt_start_o,
    output logic                                srt_sign_o,
    output logic [2:0]                          srt_channel_o,
    output logic [DATAWIDTH*MAX_DATALENGTH-1:0] srt_data_o,
    input  logic                                srt_done_i,
    input  logic [DATAWIDTH*MAX_DATALENGTH-1:0] srt_result_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [DATAWIDTH-1:0]                out_data_o,
    output logic                                out_last_o,
    output logic                                busy_o,
    output logic                                err_o
);

    localparam int AW = $clog2(MAX_DATALENGTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Most negative signed value: sorts below every real element.
    localparam logic [DATAWIDTH-1:0] PAD_SIGNED = {1'b1, {(DATAWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SORT,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t               state_q;
    logic                 sign_q;
    logic [2:0]           chan_q;
    logic [KW-1:0]        n_q;
    logic [KW-1:0]        keff_q;
    logic [KW-1:0]        cnt_q;
    logic [KW-1:0]        idx_q;
    logic [TW-1:0]        timer_q;
    logic [DATAWIDTH-1:0] buf_q    [MAX_DATALENGTH];
    logic [DATAWIDTH-1:0] result_q [MAX_DATALENGTH];

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                 cfg_fire;
    logic                 cfg_legal;
    logic [KW-1:0]        cfg_n;
    logic [KW-1:0]        cfg_keff;
    logic [DATAWIDTH-1:0] cfg_pad;
    logic                 in_fire;
    logic [KW-1:0]        cnt_nxt;
    logic [KW-1:0]        idx_nxt;

    assign cfg_fire  = cfg_valid_i & cfg_ready_o;
    assign cfg_legal = (cfg_channel_i >= 3'd1) && (cfg_channel_i <= 3'd4);
    assign cfg_n     = KW'(4) << (cfg_channel_i - 3'd1);
    assign cfg_keff  = ((cfg_k_i == '0) || (cfg_k_i > cfg_n)) ? cfg_n : cfg_k_i;
    assign cfg_pad   = cfg_sign_i ? PAD_SIGNED : '0;
    assign in_fire   = in_valid_i & in_ready_o;
    assign cnt_nxt   = cnt_q + KW'(1);
    assign idx_nxt   = idx_q + KW'(1);

    // NOTE: every signal driven from always_comb gets a default before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    always_comb begin
        srt_data_o = '0;
        for (int i = 0; i < MAX_DATALENGTH; i++) begin
            srt_data_o[i*DATAWIDTH +: DATAWIDTH] = buf_q[i];
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer: state, datapath registers and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            sign_q        <= 1'b0;
            chan_q        <= '0;
            n_q           <= '0;
            keff_q        <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            timer_q       <= '0;
            // NOTE: the buffer and result arrays are reset on purpose: the
            // sorter sees srt_data_o directly, and a defined all-zero image
            // after reset is part of the interface contract.
            for (int i = 0; i < MAX_DATALENGTH; i++) begin
                buf_q[i]    <= '0;
                result_q[i] <= '0;
            end
            cfg_ready_o   <= 1'b1;
            in_ready_o    <= 1'b0;
            srt_start_o   <= 1'b0;
            srt_sign_o    <= 1'b0;
            srt_channel_o <= '0;
            out_valid_o   <= 1'b0;
            out_data_o    <= '0;
            out_last_o    <= 1'b0;
            busy_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            // Single-cycle pulses fall back to zero unless re-asserted below.
            srt_start_o <= 1'b0;
            err_o       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (cfg_fire) begin
                        if (cfg_legal) begin
                            sign_q      <= cfg_sign_i;
                            chan_q      <= cfg_channel_i;
                            n_q         <= cfg_n;
                            keff_q      <= cfg_keff;
                            cnt_q       <= '0;
                            // Pre-filling the whole buffer with PAD covers both
                            // the slots at index N and above and the tail left
                            // empty by an early in_last_i.
                            for (int i = 0; i < MAX_DATALENGTH; i++) begin
                                buf_q[i] <= cfg_pad;
                            end
                            cfg_ready_o <= 1'b0;
                            in_ready_o  <= 1'b1;
                            busy_o      <= 1'b1;
                            state_q     <= S_LOAD;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (in_fire) begin
                        buf_q[cnt_q[AW-1:0]] <= in_data_i;
                        cnt_q                <= cnt_nxt;
                        if ((cnt_nxt == n_q) || in_last_i) begin
                            in_ready_o    <= 1'b0;
                            srt_start_o   <= 1'b1;
                            srt_sign_o    <= sign_q;
                            srt_channel_o <= chan_q;
                            timer_q       <= '0;
                            state_q       <= S_SORT;
                        end
                    end
                end

                // The timer already runs during the launch cycle so the
                // timeout pulse lands exactly TIMEOUT cycles after srt_start_o.
                S_SORT: begin
                    timer_q <= timer_q + 1'b1;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (srt_done_i) begin
                        for (int i = 0; i < MAX_DATALENGTH; i++) begin
                            result_q[i] <= srt_result_i[i*DATAWIDTH +: DATAWIDTH];
                        end
                        idx_q       <= '0;
                        out_valid_o <= 1'b1;
                        out_data_o  <= srt_result_i[DATAWIDTH-1:0];
                        out_last_o  <= (keff_q == KW'(1));
                        state_q     <= S_DRAIN;
                    end else if (timer_q >= TW'(TIMEOUT - 1)) begin
                        err_o         <= 1'b1;
                        cfg_ready_o   <= 1'b1;
                        busy_o        <= 1'b0;
                        srt_sign_o    <= 1'b0;
                        srt_channel_o <= '0;
                        state_q       <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                // Output registers change only on a handshake, so data and
                // last stay stable while the consumer stalls.
                S_DRAIN: begin
                    if (out_ready_i) begin
                        if (out_last_o) begin
                            out_valid_o   <= 1'b0;
                            out_last_o    <= 1'b0;
                            out_data_o    <= '0;
                            cfg_ready_o   <= 1'b1;
                            busy_o        <= 1'b0;
                            srt_sign_o    <= 1'b0;
                            srt_channel_o <= '0;
                            state_q       <= S_IDLE;
                        end else begin
                            idx_q      <= idx_nxt;
                            out_data_o <= result_q[idx_nxt[AW-1:0]];
                            out_last_o <= (idx_nxt == (keff_q - KW'(1)));
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sorter_batch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sorter_batch_ctrl
//
// Self-checking bench for sorter_batch_ctrl. A stand-in sorter answers each
// launch after a random delay by sorting the buffer the DUT presents. The
// expected result stream is derived from the stimulus itself: the batch
// elements plus PAD fill, sorted descending, first keff entries.
// -----------------------------------------------------------------------------
module tb_sorter_batch_ctrl;

    typedef logic [7:0] byte_q_t[$];

    logic         clk_i;
    logic         rst_ni;
    logic         cfg_valid_i;
    logic         cfg_ready_o;
    logic         cfg_sign_i;
    logic [2:0]   cfg_channel_i;
    logic [5:0]   cfg_k_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [7:0]   in_data_i;
    logic         in_last_i;
    logic         srt_start_o;
    logic         srt_sign_o;
    logic [2:0]   srt_channel_o;
    logic [255:0] srt_data_o;
    logic         srt_done_i;
    logic [255:0] srt_result_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [7:0]   out_data_o;
    logic         out_last_o;
    logic         busy_o;
    logic         err_o;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc = 0;
    int         done_cyc = 0;
    bit         no_done = 0;
    bit         spurious_en = 0;
    logic [7:0] stim [32];

    sorter_batch_ctrl dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_sign_i    (cfg_sign_i),
        .cfg_channel_i (cfg_channel_i),
        .cfg_k_i       (cfg_k_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .in_last_i     (in_last_i),
        .srt_start_o   (srt_start_o),
        .srt_sign_o    (srt_sign_o),
        .srt_channel_o (srt_channel_o),
        .srt_data_o    (srt_data_o),
        .srt_done_i    (srt_done_i),
        .srt_result_i  (srt_result_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_last_o    (out_last_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit greater(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        return sgn ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    function automatic byte_q_t sorted_desc(input byte_q_t q, input bit sgn);
        byte_q_t r;
        logic [7:0] t;
        r = q;
        for (int i = 0; i < r.size(); i++) begin
            for (int j = 0; j + 1 < r.size() - i; j++) begin
                if (greater(r[j+1], r[j], sgn)) begin
                    t      = r[j];
                    r[j]   = r[j+1];
                    r[j+1] = t;
                end
            end
        end
        return r;
    endfunction

    // Stand-in sorter: answers a launch after 1..10 cycles, holds done 1..3
    // cycles; optionally raises stray done pulses while no sort is pending.
    initial begin : sorter_model
        byte_q_t      q;
        int           n;
        logic [255:0] res;
        srt_done_i   = 1'b0;
        srt_result_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            srt_done_i = 1'b0;
            if (!rst_ni) continue;
            if (srt_start_o && !no_done) begin
                n = (srt_channel_o >= 3'd1 && srt_channel_o <= 3'd4) ? (4 << (srt_channel_o - 1)) : 4;
                q = {};
                for (int i = 0; i < n; i++) q.push_back(srt_data_o[i*8 +: 8]);
                q = sorted_desc(q, srt_sign_o);
                res = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                for (int i = 0; i < n; i++) res[i*8 +: 8] = q[i];
                repeat ($urandom_range(1, 10)) begin
                    @(posedge clk_i);
                    #1;
                end
                srt_result_i = res;
                srt_done_i   = 1'b1;
                done_cyc     = cyc;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk_i);
                    #1;
                end
                srt_done_i = 1'b0;
            end else if (spurious_en && !no_done) begin
                srt_done_i   = ($urandom_range(0, 5) == 0);
                srt_result_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready_o, 1'b1);
        check({tag, "_in_ready"}, in_ready_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_start"}, srt_start_o, 1'b0);
        check({tag, "_chan_sign"}, {srt_channel_o, srt_sign_o}, 4'd0);
        check({tag, "_out"}, {out_valid_o, out_last_o, out_data_o}, 10'd0);
        check({tag, "_err"}, err_o, 1'b0);
        check({tag, "_buf"}, srt_data_o, 256'd0);
    endtask

    // One batch: configure, load nbeats of stim[], then check launch, result
    // stream (or timeout). rst_after >= 0 pulls reset after that many results.
    task automatic run_batch(input bit sgn, input logic [2:0] ch, input logic [5:0] k,
                             input int nbeats, input bit with_last, input int rst_after);
        int           n, keff, nl, guard, got, idx;
        bit           legal, first, prev_stall, prev_last;
        logic [7:0]   pad, prev_data;
        byte_q_t      all;
        logic [255:0] eb;

        legal = (ch >= 3'd1) && (ch <= 3'd4);
        n     = legal ? (4 << (ch - 1)) : 0;
        keff  = ((k == 0) || (k > n)) ? n : int'(k);
        nl    = (nbeats < n) ? nbeats : n;
        pad   = sgn ? 8'h80 : 8'h00;

        all = {};
        for (int i = 0; i < n; i++) all.push_back((i < nl) ? stim[i] : pad);
        all = sorted_desc(all, sgn);
        eb = '0;
        for (int i = 0; i < 32; i++) eb[i*8 +: 8] = (i < nl) ? stim[i] : pad;

        cfg_valid_i   = 1'b1;
        cfg_sign_i    = sgn;
        cfg_channel_i = ch;
        cfg_k_i       = k;
        guard = 0;
        while (!cfg_ready_o && guard < 100) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        check("cfg_ready_wait", guard < 100, 1'b1);
        @(posedge clk_i);
        #1;
        cfg_valid_i   = 1'b0;
        cfg_k_i       = 6'($urandom);
        cfg_channel_i = 3'($urandom);
        cfg_sign_i    = 1'($urandom);

        if (!legal) begin
            check("illegal_err_pulse", err_o, 1'b1);
            check("illegal_busy", busy_o, 1'b0);
            check("illegal_cfg_ready", cfg_ready_o, 1'b1);
            @(posedge clk_i);
            #1;
            check("illegal_err_clear", err_o, 1'b0);
            check("illegal_no_start", {srt_start_o, busy_o}, 2'b00);
            return;
        end

        check("load_in_ready", in_ready_o, 1'b1);
        check("load_busy", busy_o, 1'b1);
        check("load_cfg_ready", cfg_ready_o, 1'b0);

        got   = 0;
        guard = 0;
        while (got < nl && guard < 1000) begin
            in_valid_i = ($urandom_range(0, 3) != 0);
            in_data_i  = stim[got];
            in_last_i  = with_last && (got == nl - 1);
            if (in_valid_i && in_ready_o) got++;
            @(posedge clk_i);
            #1;
            guard++;
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        check("load_beats", got, nl);

        check("start_pulse", srt_start_o, 1'b1);
        check("start_channel", srt_channel_o, ch);
        check("start_sign", srt_sign_o, sgn);
        check("start_in_ready_low", in_ready_o, 1'b0);
        check("start_buffer", srt_data_o, eb);
        @(posedge clk_i);
        #1;
        check("start_single_cycle", srt_start_o, 1'b0);
        check("channel_hold", {srt_channel_o, srt_sign_o}, {ch, sgn});

        if (no_done) begin
            guard = 1;
            while (!err_o && !out_valid_o && guard < 100) begin
                @(posedge clk_i);
                #1;
                guard++;
            end
            check("timeout_cycles", guard, 64);
            check("timeout_no_output", out_valid_o, 1'b0);
            check("timeout_idle", {busy_o, cfg_ready_o, srt_channel_o}, {1'b0, 1'b1, 3'd0});
            @(posedge clk_i);
            #1;
            check("timeout_err_clear", err_o, 1'b0);
            return;
        end

        idx        = 0;
        first      = 1'b1;
        prev_stall = 1'b0;
        prev_last  = 1'b0;
        prev_data  = '0;
        guard      = 0;
        while (guard < 2000 && idx < keff) begin
            if (rst_after >= 0 && idx == rst_after) begin
                #2;
                rst_ni = 1'b0;
                #1;
                check_reset_state("midreset");
                out_ready_i = 1'b0;
                @(posedge clk_i);
                #1;
                rst_ni = 1'b1;
                @(posedge clk_i);
                #1;
                check("after_reset_cfg_ready", cfg_ready_o, 1'b1);
                return;
            end
            if (out_valid_o) begin
                if (first) begin
                    check("first_out_latency", cyc, done_cyc + 1);
                    first = 1'b0;
                end
                if (prev_stall) begin
                    check("stall_data", out_data_o, prev_data);
                    check("stall_last", out_last_o, prev_last);
                end
                out_ready_i = ($urandom_range(0, 2) != 0);
                if (out_ready_i) begin
                    check("out_data", out_data_o, all[idx]);
                    check("out_last", out_last_o, idx == keff - 1);
                    idx++;
                end
                prev_stall = !out_ready_i;
                prev_data  = out_data_o;
                prev_last  = out_last_o;
            end else begin
                out_ready_i = 1'($urandom);
                prev_stall  = 1'b0;
            end
            @(posedge clk_i);
            #1;
            guard++;
        end
        out_ready_i = 1'b0;
        check("drain_count", idx, keff);
        check("drain_end_idle", {out_valid_o, busy_o, cfg_ready_o, srt_channel_o}, {1'b0, 1'b0, 1'b1, 3'd0});
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no completion expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit         sgn;
        logic [2:0] ch;
        int         n, nb;

        rst_ni        = 1'b0;
        cfg_valid_i   = 1'b0;
        cfg_sign_i    = 1'b0;
        cfg_channel_i = '0;
        cfg_k_i       = '0;
        in_valid_i    = 1'b0;
        in_data_i     = '0;
        in_last_i     = 1'b0;
        out_ready_i   = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        check_reset_state("reset");
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Unsigned, 4 elements, k = 0 -> all four, largest first.
        stim[0] = 8'd3; stim[1] = 8'd9; stim[2] = 8'd1; stim[3] = 8'd7;
        run_batch(1'b0, 3'd1, 6'd0, 4, 1'b0, -1);

        // Signed, 8-element channel, early last after 5 beats, k = 3.
        stim[0] = 8'h05; stim[1] = 8'hFF; stim[2] = 8'h7F; stim[3] = 8'h80; stim[4] = 8'h01;
        run_batch(1'b1, 3'd2, 6'd3, 5, 1'b1, -1);

        // Full 32-element batch, k above N clamps to 32.
        for (int i = 0; i < 32; i++) stim[i] = 8'($urandom);
        run_batch(1'b0, 3'd4, 6'd40, 32, 1'b0, -1);

        // Illegal channels.
        run_batch(1'b0, 3'd5, 6'd2, 4, 1'b0, -1);
        run_batch(1'b1, 3'd0, 6'd2, 4, 1'b0, -1);

        // Sorter never answers.
        for (int i = 0; i < 32; i++) stim[i] = 8'($urandom);
        no_done = 1'b1;
        run_batch(1'b1, 3'd3, 6'd5, 16, 1'b1, -1);
        no_done = 1'b0;
        run_batch(1'b0, 3'd1, 6'd2, 4, 1'b1, -1);

        // Stalled drain, then reset in the middle of it; then a clean batch.
        for (int i = 0; i < 32; i++) stim[i] = 8'($urandom);
        run_batch(1'b0, 3'd3, 6'd10, 16, 1'b0, 4);
        run_batch(1'b1, 3'd2, 6'd8, 8, 1'b1, -1);

        // Randomized batches with stray done pulses outside the wait window.
        spurious_en = 1'b1;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 32; i++) stim[i] = 8'($urandom);
            sgn = 1'($urandom);
            ch  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
            n   = (ch >= 3'd1 && ch <= 3'd4) ? (4 << (ch - 1)) : 4;
            nb  = ($urandom_range(0, 1) == 1) ? n : $urandom_range(1, n);
            run_batch(sgn, ch, 6'($urandom), nb, (nb < n) ? 1'b1 : 1'($urandom), -1);
        end
        spurious_en = 1'b0;

        repeat (2) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
